note_lane_engine: RTL

- Parametrised rhythm-game core: scrolls an N-lane note chart through a visible window at a programmable beat period, scores button presses against the hit zone, and tracks hits, misses, combo and score.
- Next-generation gameplay block beside the mode FSM and the difficulty-speed logic.
- Generalises the fixed two-lane, 32-note engine to any lane count, chart length and window depth.
- Adds a combo multiplier, a saturating score, explicit start/busy/done handshaking, and a one-cycle finish pulse.

---
 rtl/note_lane_engine_if.sv | 36 +++
 rtl/note_lane_engine.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/note_lane_engine_if.sv
// Signal bundle between the rhythm-game core and its host: round control,
// chart/period setup, lane buttons, the visible window and the scoreboard.
interface note_lane_engine_if #(
    parameter int LANES     = 2,
    parameter int CHART_LEN = 32,
    parameter int VIS_LEN   = 8,
    parameter int SPEED_W   = 23,
    parameter int CNT_W     = 8
);
    logic                         start;
    logic [LANES*CHART_LEN-1:0]   chart;
    logic [SPEED_W-1:0]           period;
    logic [LANES-1:0]             buttons;
    logic [LANES*VIS_LEN-1:0]     window;
    logic                         hit_pulse;
    logic                         miss_pulse;
    logic [CNT_W-1:0]             score;
    logic [CNT_W-1:0]             hits;
    logic [CNT_W-1:0]             misses;
    logic [CNT_W-1:0]             combo;
    logic                         busy;
    logic                         done;
    logic                         finish;

    modport master (
        output start, chart, period, buttons,
        input  window, hit_pulse, miss_pulse, score, hits, misses, combo,
               busy, done, finish
    );

    modport slave (
        input  start, chart, period, buttons,
        output window, hit_pulse, miss_pulse, score, hits, misses, combo,
               busy, done, finish
    );
endinterface

// File: rtl/note_lane_engine.sv
// N-lane rhythm-game core: scrolls a latched chart through a window at a
// programmable beat period and scores button presses against column 0.
module note_lane_engine #(
    parameter int LANES       = 2,
    parameter int CHART_LEN   = 32,
    parameter int VIS_LEN     = 8,
    parameter int SPEED_W     = 23,
    parameter int CNT_W       = 8,
    parameter int COMBO_BONUS = 4
) (
    input  logic               hwclk,
    input  logic               reset,
    note_lane_engine_if.slave  bus
);
    localparam int IDX_W = $clog2(CHART_LEN + VIS_LEN + 1);
    localparam int NW    = $clog2(2 * LANES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   BONUS     = (CNT_W+1)'(COMBO_BONUS);
    localparam logic [IDX_W-1:0] LAST_TICK = IDX_W'(CHART_LEN + VIS_LEN - 1);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t                     state_reg, state_next;
    logic                       start_acc, play, tick, final_tick;
    logic [LANES*CHART_LEN-1:0] chart_reg;
    logic [SPEED_W-1:0]         period_reg, beat_reg;
    // Note index and tick count advance together, so one register serves both.
    logic [IDX_W-1:0]           idx_reg;
    logic [LANES-1:0]           btn_prev_reg, rise, hit, miss;
    logic [LANES*VIS_LEN-1:0]   window_reg, window_next;
    logic [CNT_W-1:0]           score_reg, hits_reg, misses_reg, combo_reg;
    logic                       hit_pulse_reg, miss_pulse_reg;
    logic                       busy_reg, done_reg, finish_reg;
    logic [NW-1:0]              nh, nm, points;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [NW-1:0] b);
        logic [CNT_W+NW:0] s;
        s = (CNT_W+NW+1)'(a) + (CNT_W+NW+1)'(b);
        return (s > (CNT_W+NW+1)'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    assign play       = (state_reg == PLAY);
    assign start_acc  = bus.start && (state_reg == IDLE || state_reg == DONE);
    assign tick       = play && (beat_reg == period_reg - 1'b1);
    assign final_tick = tick && (idx_reg == LAST_TICK);
    assign rise       = bus.buttons & ~btn_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [VIS_LEN-1:0]   lane_win, lane_shift, lane_next;
            logic [2**IDX_W-1:0]  lane_chart;
            logic                 col0;

            assign lane_win   = window_reg[gi*VIS_LEN +: VIS_LEN];
            // Zero padding past the chart end feeds empty columns once idx runs out.
            assign lane_chart = {{(2**IDX_W-CHART_LEN){1'b0}},
                                 chart_reg[gi*CHART_LEN +: CHART_LEN]};
            assign col0       = lane_win[0];
            assign hit[gi]    = play && rise[gi] && col0;
            assign miss[gi]   = (play && rise[gi] && !col0) ||
                                (tick && col0 && !hit[gi]);

            if (VIS_LEN > 1) begin : g_shift
                assign lane_shift = {lane_chart[idx_reg], lane_win[VIS_LEN-1:1]};
            end else begin : g_single
                assign lane_shift = lane_chart[idx_reg];
            end

            // A hit forces column 0 empty even when a tick shifts in the same cycle.
            assign lane_next = (tick ? lane_shift : lane_win) & ~VIS_LEN'(hit[gi]);
            assign window_next[gi*VIS_LEN +: VIS_LEN] = lane_next;
        end
    endgenerate

    always_comb begin
        nh = '0;
        nm = '0;
        for (int l = 0; l < LANES; l++) begin
            nh = nh + NW'(hit[l]);
            nm = nm + NW'(miss[l]);
        end
        points = ({1'b0, combo_reg} >= BONUS) ? (nh << 1) : nh;
    end

    always_ff @(posedge hwclk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = PLAY;
            PLAY:    if (final_tick) state_next = DONE;
            DONE:    if (bus.start) state_next = PLAY;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            chart_reg      <= '0;
            period_reg     <= '0;
            beat_reg       <= '0;
            idx_reg        <= '0;
            btn_prev_reg   <= '0;
            window_reg     <= '0;
            score_reg      <= '0;
            hits_reg       <= '0;
            misses_reg     <= '0;
            combo_reg      <= '0;
            hit_pulse_reg  <= 1'b0;
            miss_pulse_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            finish_reg     <= 1'b0;
        end else begin
            btn_prev_reg <= start_acc ? '0 : bus.buttons;
            busy_reg     <= (state_next == PLAY);
            done_reg     <= (state_next == DONE);
            finish_reg   <= final_tick;
            if (start_acc) begin
                chart_reg      <= bus.chart;
                period_reg     <= (bus.period == '0) ? SPEED_W'(1) : bus.period;
                beat_reg       <= '0;
                idx_reg        <= '0;
                window_reg     <= '0;
                score_reg      <= '0;
                hits_reg       <= '0;
                misses_reg     <= '0;
                combo_reg      <= '0;
                hit_pulse_reg  <= 1'b0;
                miss_pulse_reg <= 1'b0;
            end else begin
                window_reg <= window_next;
                if (play) beat_reg <= tick ? '0 : beat_reg + 1'b1;
                if (tick) idx_reg <= idx_reg + 1'b1;
                hit_pulse_reg  <= (nh != '0);
                miss_pulse_reg <= (nm != '0);
                hits_reg       <= sat_add(hits_reg, nh);
                misses_reg     <= sat_add(misses_reg, nm);
                score_reg      <= sat_add(score_reg, points);
                combo_reg      <= (nm != '0) ? '0 : sat_add(combo_reg, nh);
            end
        end
    end

    assign bus.window     = window_reg;
    assign bus.hit_pulse  = hit_pulse_reg;
    assign bus.miss_pulse = miss_pulse_reg;
    assign bus.score      = score_reg;
    assign bus.hits       = hits_reg;
    assign bus.misses     = misses_reg;
    assign bus.combo      = combo_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.finish     = finish_reg;
endmodule
